// File: rtl/obuf_cfg_pkg.sv
// obuf_cfg_pkg: word field positions, header tag and descriptor type for obuf_cfg_issuer
package obuf_cfg_pkg;
  localparam logic [3:0] OBUF_CFG_HDR_TAG = 4'hA;
  localparam int W0_FLAG_LSB = 0, W0_FLAG_MSB = 12;
  localparam int W0_KSZ_LSB = 13, W0_KSZ_MSB = 16;
  localparam int W0_KST_LSB = 17, W0_KST_MSB = 20;
  localparam int W0_PSZ_LSB = 21, W0_PSZ_MSB = 22;
  localparam int W0_PST_LSB = 23, W0_PST_MSB = 24;
  localparam int W0_BS_LSB = 25, W0_BS_MSB = 26;
  localparam int W0_TAG_LSB = 28, W0_TAG_MSB = 31;
  localparam int W1_X_LSB = 0, W1_X_MSB = 5;
  localparam int W1_Y_LSB = 6, W1_Y_MSB = 11;
  localparam int W1_XP_LSB = 12, W1_XP_MSB = 17;
  localparam int W1_YP_LSB = 18, W1_YP_MSB = 23;
  localparam int W2_PE_LSB = 0, W2_PE_MSB = 5;
  localparam int W2_NORM_LSB = 6, W2_NORM_MSB = 11;
  localparam int W2_ACT_LSB = 12, W2_ACT_MSB = 17;
  localparam int W2_NEXT_LSB = 18, W2_NEXT_MSB = 23;
  localparam int W2_PNEXT_LSB = 24, W2_PNEXT_MSB = 29;
  localparam int W3_LEAKY_LSB = 0, W3_LEAKY_MSB = 15;
  localparam int W3_ICP_LSB = 16, W3_ICP_MSB = 17;
  localparam int W3_OCP_LSB = 18, W3_OCP_MSB = 19;
  localparam int W3_ACCU = 20, W3_LICH = 21, W3_LKER = 22, W3_FINAL = 23;
  localparam int W3_CONV_LSB = 24, W3_CONV_MSB = 25;
  typedef struct packed {
    logic [12:0] flags;
    logic [3:0] ker_size;
    logic [3:0] ker_strd;
    logic [1:0] pool_size;
    logic [1:0] pool_strd;
    logic [1:0] bit_serial;
    logic [5:0] tile_x;
    logic [5:0] tile_y;
    logic [5:0] tile_xp;
    logic [5:0] tile_yp;
    logic [5:0] q_pe;
    logic [5:0] q_norm;
    logic [5:0] q_act;
    logic [5:0] q_next;
    logic [5:0] q_pool_next;
    logic [15:0] leaky;
    logic [1:0] icp;
    logic [1:0] ocp;
    logic accu;
    logic last_ich;
    logic last_ker;
    logic final_tile;
    logic [1:0] conv_flag;
  } obuf_desc_t;
endpackage

// File: rtl/obuf_cfg_collect.sv
// obuf_cfg_collect: assembles four cfg words into a shadow descriptor; OBUF_CFG_HDR_CHECK_EN drops W0 with a bad tag
module obuf_cfg_collect
  import obuf_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        take,
  output obuf_desc_t  shadow,
  output logic        shadow_full,
  output logic        cfg_err
);
  logic [1:0] wcnt;
  logic acc, drop, unused_hdr;
  assign cfg_ready = !shadow_full;
  assign acc = cfg_valid && cfg_ready;
  assign unused_hdr = ^cfg_data[31:27];
`ifdef OBUF_CFG_HDR_CHECK_EN
  assign drop = wcnt == 2'd0 && cfg_data[W0_TAG_MSB:W0_TAG_LSB] != OBUF_CFG_HDR_TAG;
`else
  assign drop = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
      shadow_full <= 1'b0;
      shadow <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (take) shadow_full <= 1'b0;
      if (acc && drop) cfg_err <= 1'b1;
      if (acc && !drop) begin
        wcnt <= wcnt + 2'd1;
        if (wcnt == 2'd3) shadow_full <= 1'b1;
        case (wcnt)
          2'd0: begin
            shadow.flags <= cfg_data[W0_FLAG_MSB:W0_FLAG_LSB];
            shadow.ker_size <= cfg_data[W0_KSZ_MSB:W0_KSZ_LSB];
            shadow.ker_strd <= cfg_data[W0_KST_MSB:W0_KST_LSB];
            shadow.pool_size <= cfg_data[W0_PSZ_MSB:W0_PSZ_LSB];
            shadow.pool_strd <= cfg_data[W0_PST_MSB:W0_PST_LSB];
            shadow.bit_serial <= cfg_data[W0_BS_MSB:W0_BS_LSB];
          end
          2'd1: begin
            shadow.tile_x <= cfg_data[W1_X_MSB:W1_X_LSB];
            shadow.tile_y <= cfg_data[W1_Y_MSB:W1_Y_LSB];
            shadow.tile_xp <= cfg_data[W1_XP_MSB:W1_XP_LSB];
            shadow.tile_yp <= cfg_data[W1_YP_MSB:W1_YP_LSB];
          end
          2'd2: begin
            shadow.q_pe <= cfg_data[W2_PE_MSB:W2_PE_LSB];
            shadow.q_norm <= cfg_data[W2_NORM_MSB:W2_NORM_LSB];
            shadow.q_act <= cfg_data[W2_ACT_MSB:W2_ACT_LSB];
            shadow.q_next <= cfg_data[W2_NEXT_MSB:W2_NEXT_LSB];
            shadow.q_pool_next <= cfg_data[W2_PNEXT_MSB:W2_PNEXT_LSB];
          end
          default: begin
            shadow.leaky <= cfg_data[W3_LEAKY_MSB:W3_LEAKY_LSB];
            shadow.icp <= cfg_data[W3_ICP_MSB:W3_ICP_LSB];
            shadow.ocp <= cfg_data[W3_OCP_MSB:W3_OCP_LSB];
            shadow.accu <= cfg_data[W3_ACCU];
            shadow.last_ich <= cfg_data[W3_LICH];
            shadow.last_ker <= cfg_data[W3_LKER];
            shadow.final_tile <= cfg_data[W3_FINAL];
            shadow.conv_flag <= cfg_data[W3_CONV_MSB:W3_CONV_LSB];
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/obuf_cfg_issuer.sv
// obuf_cfg_issuer: issues assembled descriptors to the output-buffer settings register, one per obuf_done (OBUF_CFG_HDR_CHECK_EN enables header check)
module obuf_cfg_issuer
  import obuf_cfg_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int HALF_ADDR_SIZE = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               cfg_data,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      obuf_done,
  output logic                      obuf_rst,
  output logic                      pwc_dwc_combine,
  output logic                      concat_output_control,
  output logic                      set_isize,
  output logic                      set_wsize,
  output logic                      batch_first,
  output logic                      have_batch,
  output logic                      have_batch_dwc,
  output logic                      have_relu,
  output logic                      have_relu_dwc,
  output logic                      have_leaky,
  output logic                      have_sigmoid,
  output logic                      have_pool,
  output logic                      Is_Upsample,
  output logic                      have_accu,
  output logic                      have_last_ich,
  output logic                      Is_last_ker,
  output logic                      Is_Final_Tile,
  output logic [3:0]                ker_size,
  output logic [3:0]                ker_strd,
  output logic [1:0]                pool_size,
  output logic [1:0]                pool_strd,
  output logic [1:0]                Bit_serial,
  output logic [1:0]                hw_icp_able_cacl,
  output logic [1:0]                hw_ocp_able_cacl,
  output logic [1:0]                CONV_FLAG,
  output logic [HALF_ADDR_SIZE-1:0] obuf_tile_size_x,
  output logic [HALF_ADDR_SIZE-1:0] obuf_tile_size_y,
  output logic [HALF_ADDR_SIZE-1:0] obuf_tile_size_x_aft_pool,
  output logic [HALF_ADDR_SIZE-1:0] obuf_tile_size_y_aft_pool,
  output logic [5:0]                quant_pe,
  output logic [5:0]                quant_normalization,
  output logic [5:0]                quant_activation,
  output logic [5:0]                quant_next_layer,
  output logic [5:0]                quant_pool_next_layer,
  output logic [WORD_SIZE-1:0]      leaky_constant,
  output logic                      busy,
  output logic [15:0]               tile_count,
  output logic                      cfg_err
);
  obuf_desc_t shadow, cur;
  logic shadow_full, issue;
  assign issue = shadow_full && (!busy || obuf_done);
  obuf_cfg_collect u_collect (
    .clk(clk),
    .rst(rst),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .take(issue),
    .shadow(shadow),
    .shadow_full(shadow_full),
    .cfg_err(cfg_err)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= '0;
      obuf_rst <= 1'b0;
      busy <= 1'b0;
      tile_count <= '0;
    end else begin
      obuf_rst <= issue;
      if (issue) begin
        cur <= shadow;
        busy <= 1'b1;
        tile_count <= tile_count + 16'd1;
      end else if (obuf_done) begin
        busy <= 1'b0;
      end
    end
  end
  assign {Is_Upsample, have_pool, have_sigmoid, have_leaky, have_relu_dwc, have_relu, have_batch_dwc,
          have_batch, batch_first, set_wsize, set_isize, concat_output_control, pwc_dwc_combine} = cur.flags;
  assign ker_size = cur.ker_size;
  assign ker_strd = cur.ker_strd;
  assign pool_size = cur.pool_size;
  assign pool_strd = cur.pool_strd;
  assign Bit_serial = cur.bit_serial;
  assign obuf_tile_size_x = cur.tile_x[HALF_ADDR_SIZE-1:0];
  assign obuf_tile_size_y = cur.tile_y[HALF_ADDR_SIZE-1:0];
  assign obuf_tile_size_x_aft_pool = cur.tile_xp[HALF_ADDR_SIZE-1:0];
  assign obuf_tile_size_y_aft_pool = cur.tile_yp[HALF_ADDR_SIZE-1:0];
  assign quant_pe = cur.q_pe;
  assign quant_normalization = cur.q_norm;
  assign quant_activation = cur.q_act;
  assign quant_next_layer = cur.q_next;
  assign quant_pool_next_layer = cur.q_pool_next;
  assign leaky_constant = cur.leaky[WORD_SIZE-1:0];
  assign hw_icp_able_cacl = cur.icp;
  assign hw_ocp_able_cacl = cur.ocp;
  assign have_accu = cur.accu;
  assign have_last_ich = cur.last_ich;
  assign Is_last_ker = cur.last_ker;
  assign Is_Final_Tile = cur.final_tile;
  assign CONV_FLAG = cur.conv_flag;
endmodule

// File: tb/tb_obuf_cfg_issuer.sv
// tb_obuf_cfg_issuer: scoreboard bench for obuf_cfg_issuer, header-check expectations follow OBUF_CFG_HDR_CHECK_EN
module tb_obuf_cfg_issuer;
  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, obuf_done = 1'b0;
  logic [31:0] cfg_data = '0;
  logic cfg_ready, obuf_rst, busy, cfg_err;
  logic pwc_dwc_combine, concat_output_control, set_isize, set_wsize, batch_first, have_batch, have_batch_dwc;
  logic have_relu, have_relu_dwc, have_leaky, have_sigmoid, have_pool, Is_Upsample, have_accu, have_last_ich;
  logic Is_last_ker, Is_Final_Tile;
  logic [3:0] ker_size, ker_strd;
  logic [1:0] pool_size, pool_strd, Bit_serial, hw_icp_able_cacl, hw_ocp_able_cacl, CONV_FLAG;
  logic [5:0] obuf_tile_size_x, obuf_tile_size_y, obuf_tile_size_x_aft_pool, obuf_tile_size_y_aft_pool;
  logic [5:0] quant_pe, quant_normalization, quant_activation, quant_next_layer, quant_pool_next_layer;
  logic [15:0] leaky_constant, tile_count;
  int total = 0, bad = 0;
  typedef struct {
    logic hb;
    logic [3:0] ks;
    logic [5:0] tx, ty, txp, typ, qpe;
    logic [15:0] leaky;
    logic fin;
    logic [15:0] tc;
  } exp_t;
  exp_t sb[$];
  obuf_cfg_issuer dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .obuf_done(obuf_done), .obuf_rst(obuf_rst),
    .pwc_dwc_combine(pwc_dwc_combine), .concat_output_control(concat_output_control),
    .set_isize(set_isize), .set_wsize(set_wsize), .batch_first(batch_first), .have_batch(have_batch),
    .have_batch_dwc(have_batch_dwc), .have_relu(have_relu), .have_relu_dwc(have_relu_dwc),
    .have_leaky(have_leaky), .have_sigmoid(have_sigmoid), .have_pool(have_pool), .Is_Upsample(Is_Upsample),
    .have_accu(have_accu), .have_last_ich(have_last_ich), .Is_last_ker(Is_last_ker),
    .Is_Final_Tile(Is_Final_Tile), .ker_size(ker_size), .ker_strd(ker_strd), .pool_size(pool_size),
    .pool_strd(pool_strd), .Bit_serial(Bit_serial), .hw_icp_able_cacl(hw_icp_able_cacl),
    .hw_ocp_able_cacl(hw_ocp_able_cacl), .CONV_FLAG(CONV_FLAG),
    .obuf_tile_size_x(obuf_tile_size_x), .obuf_tile_size_y(obuf_tile_size_y),
    .obuf_tile_size_x_aft_pool(obuf_tile_size_x_aft_pool), .obuf_tile_size_y_aft_pool(obuf_tile_size_y_aft_pool),
    .quant_pe(quant_pe), .quant_normalization(quant_normalization), .quant_activation(quant_activation),
    .quant_next_layer(quant_next_layer), .quant_pool_next_layer(quant_pool_next_layer),
    .leaky_constant(leaky_constant), .busy(busy), .tile_count(tile_count), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask
  function automatic logic all_fields_or();
    return |{pwc_dwc_combine, concat_output_control, set_isize, set_wsize, batch_first, have_batch,
             have_batch_dwc, have_relu, have_relu_dwc, have_leaky, have_sigmoid, have_pool, Is_Upsample,
             have_accu, have_last_ich, Is_last_ker, Is_Final_Tile, ker_size, ker_strd, pool_size, pool_strd,
             Bit_serial, hw_icp_able_cacl, hw_ocp_able_cacl, CONV_FLAG, obuf_tile_size_x, obuf_tile_size_y,
             obuf_tile_size_x_aft_pool, obuf_tile_size_y_aft_pool, quant_pe, quant_normalization,
             quant_activation, quant_next_layer, quant_pool_next_layer, leaky_constant};
  endfunction
  always @(negedge clk) begin
    if (!rst && obuf_rst) begin
      if (sb.size() == 0) begin
        check("unexpected_obuf_rst", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("have_batch", 32'(have_batch), 32'(e.hb));
        check("ker_size", 32'(ker_size), 32'(e.ks));
        check("tile_x", 32'(obuf_tile_size_x), 32'(e.tx));
        check("tile_y", 32'(obuf_tile_size_y), 32'(e.ty));
        check("tile_x_aft_pool", 32'(obuf_tile_size_x_aft_pool), 32'(e.txp));
        check("tile_y_aft_pool", 32'(obuf_tile_size_y_aft_pool), 32'(e.typ));
        check("quant_pe", 32'(quant_pe), 32'(e.qpe));
        check("leaky_constant", 32'(leaky_constant), 32'(e.leaky));
        check("Is_Final_Tile", 32'(Is_Final_Tile), 32'(e.fin));
        check("tile_count", 32'(tile_count), 32'(e.tc));
        check("busy_at_issue", 32'(busy), 32'd1);
      end
    end
  end
  task automatic send(input logic [31:0] w);
    int n = 0;
    cfg_data = w;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cfg_ready) check("cfg_ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic pulse_done();
    obuf_done = 1'b1;
    tick();
    obuf_done = 1'b0;
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_fields"}, 32'(all_fields_or()), 32'd0);
    check({tag, "_tile_count"}, 32'(tile_count), 32'd0);
    check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
    check({tag, "_obuf_rst"}, 32'(obuf_rst), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check_reset_state("reset");
    sb.push_back('{hb: 1'b1, ks: 4'd3, tx: 6'd26, ty: 6'd16, txp: 6'd8, typ: 6'd8, qpe: 6'd0,
                   leaky: 16'h0019, fin: 1'b1, tc: 16'd1});
    send(32'hA0006020);
    send(32'h0020841A);
    send(32'h00000000);
    send(32'h00800019);
    check("lat_rst_low_after_w3", 32'(obuf_rst), 32'd0);
    check("ready_low_after_w3", 32'(cfg_ready), 32'd0);
    tick();
    check("lat_rst_high", 32'(obuf_rst), 32'd1);
    check("ready_high_after_issue", 32'(cfg_ready), 32'd1);
    tick();
    check("rst_single_cycle", 32'(obuf_rst), 32'd0);
    check("busy_held", 32'(busy), 32'd1);
    send(32'hA000A000);
    send(32'h0028550A);
    send(32'h00000007);
    send(32'h00001234);
    repeat (3) tick();
    check("prefetch_ready_low", 32'(cfg_ready), 32'd0);
    check("prefetch_busy", 32'(busy), 32'd1);
    check("prefetch_old_ker", 32'(ker_size), 32'd3);
    sb.push_back('{hb: 1'b0, ks: 4'd5, tx: 6'd10, ty: 6'd20, txp: 6'd5, typ: 6'd10, qpe: 6'd7,
                   leaky: 16'h1234, fin: 1'b0, tc: 16'd2});
    pulse_done();
    check("b2b_rst_high", 32'(obuf_rst), 32'd1);
    check("b2b_busy", 32'(busy), 32'd1);
    tick();
    check("b2b_rst_low", 32'(obuf_rst), 32'd0);
    pulse_done();
    check("done_clears_busy", 32'(busy), 32'd0);
    pulse_done();
    tick();
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_tile_count", 32'(tile_count), 32'd2);
    check("stray_ker_hold", 32'(ker_size), 32'd5);
    check("stray_leaky_hold", 32'(leaky_constant), 32'h1234);
    sb.push_back('{hb: 1'b1, ks: 4'd0, tx: 6'd63, ty: 6'd0, txp: 6'd0, typ: 6'd0, qpe: 6'd3,
                   leaky: 16'hFFFF, fin: 1'b1, tc: 16'd3});
`ifdef OBUF_CFG_HDR_CHECK_EN
    send(32'h5000E000);
    repeat (2) tick();
    check("hdr_err_set", 32'(cfg_err), 32'd1);
    check("hdr_no_issue", 32'(tile_count), 32'd2);
    send(32'hA0000020);
`else
    send(32'h50000020);
`endif
    send(32'h0000003F);
    send(32'h00000003);
    send(32'h0080FFFF);
    repeat (2) tick();
    check("hdr_tile_count", 32'(tile_count), 32'd3);
`ifdef OBUF_CFG_HDR_CHECK_EN
    check("hdr_err_sticky", 32'(cfg_err), 32'd1);
`else
    check("hdr_err_tied", 32'(cfg_err), 32'd0);
`endif
    send(32'hA001E020);
    send(32'h00FFFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("midreset");
    sb.push_back('{hb: 1'b0, ks: 4'd2, tx: 6'd1, ty: 6'd0, txp: 6'd0, typ: 6'd0, qpe: 6'd0,
                   leaky: 16'h0042, fin: 1'b0, tc: 16'd1});
    send(32'hA0004000);
    send(32'h00000001);
    send(32'h00000000);
    send(32'h00000042);
    repeat (3) tick();
    check("fresh_tile_count", 32'(tile_count), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
